// File: rtl/control_sequencer.sv
// Control sequencer for the 8-bit accumulator CPU.
// A one-hot T1..T6 ring plus a HALT state. The fetch steps (T1-T3) are the
// same for every instruction. The execute steps (T4-T6) are decoded from the
// IR opcode. Every control output is a combinational decode of the registered
// state, the registered compare flag and the opcode. cp is only ever
// registered, so it has no combinational path to any output.
module control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    input  logic       cp,
    output logic       ep,
    output logic       inc_pc,
    output logic       lj,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       lb,
    output logic       ea,
    output logic       ev,
    output logic       co,
    output logic       n,
    output logic       lo,
    output logic       hlt,
    output logic       flag_gt,
    output logic [5:0] t_state
);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_CMP = 4'h3;
    localparam logic [3:0] OP_JGT = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot encoding. The low six bits are the externally visible T-state
    // ring. HALT sits in its own bit, so t_state reads 0 while halted.
    typedef enum logic [6:0] {
        S_T1   = 7'b0000001,
        S_T2   = 7'b0000010,
        S_T3   = 7'b0000100,
        S_T4   = 7'b0001000,
        S_T5   = 7'b0010000,
        S_T6   = 7'b0100000,
        S_HALT = 7'b1000000
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   flag_q;
    logic   flag_d;

    // Opcode classes used by the execute decode.
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_cmp;
    logic is_jgt;
    logic is_jmp;
    logic is_out;
    logic is_hlt;
    logic mem_operand;   // instructions that fetch an operand via MAR in T4
    logic alu_op;        // ADD/SUB: operand into B, then the adder result into A

    assign is_lda      = (opcode == OP_LDA);
    assign is_add      = (opcode == OP_ADD);
    assign is_sub      = (opcode == OP_SUB);
    assign is_cmp      = (opcode == OP_CMP);
    assign is_jgt      = (opcode == OP_JGT);
    assign is_jmp      = (opcode == OP_JMP);
    assign is_out      = (opcode == OP_OUT);
    assign is_hlt      = (opcode == OP_HLT);
    assign mem_operand = is_lda | is_add | is_sub | is_cmp;
    assign alu_op      = is_add | is_sub;

    // State and compare-flag registers. clr overrides everything, including HALT.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_T1;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state ring. HLT leaves the ring at the end of T4. Only clr exits HALT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = is_hlt ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    // The compare flag is written only as CMP leaves T6, and it holds otherwise.
    always_comb begin
        flag_d = flag_q;
        if ((state_q == S_T6) && is_cmp) begin
            flag_d = cp;
        end
    end

    // Control-word decode. Only one bus driver (ep/ce/ei/ea/ev) is selected
    // in any state.
    always_comb begin
        ep     = 1'b0;
        inc_pc = 1'b0;
        lj     = 1'b0;
        lm     = 1'b0;
        ce     = 1'b0;
        li     = 1'b0;
        ei     = 1'b0;
        la     = 1'b0;
        lb     = 1'b0;
        ea     = 1'b0;
        ev     = 1'b0;
        co     = 1'b0;
        n      = 1'b0;
        lo     = 1'b0;
        unique case (state_q)
            // Fetch: PC to MAR, increment PC, RAM to IR.
            S_T1: begin
                ep = 1'b1;
                lm = 1'b1;
            end
            S_T2: begin
                inc_pc = 1'b1;
            end
            S_T3: begin
                ce = 1'b1;
                li = 1'b1;
            end
            // T4: the operand address goes to MAR, the jump target goes to PC,
            // or A goes to the output register.
            S_T4: begin
                if (mem_operand) begin
                    ei = 1'b1;
                    lm = 1'b1;
                end
                if (is_jmp || (is_jgt && flag_q)) begin
                    ei = 1'b1;
                    lj = 1'b1;
                end
                if (is_out) begin
                    ea = 1'b1;
                    lo = 1'b1;
                end
            end
            // T5: the memory operand goes into A (LDA) or into B (ALU/compare).
            S_T5: begin
                if (mem_operand) begin
                    ce = 1'b1;
                end
                if (is_lda) begin
                    la = 1'b1;
                end
                if (alu_op || is_cmp) begin
                    lb = 1'b1;
                end
                if (is_sub) begin
                    n = 1'b1;
                end
            end
            // T6: write the adder result back to A, or gate the comparator.
            S_T6: begin
                if (alu_op) begin
                    ev = 1'b1;
                    la = 1'b1;
                end
                if (is_sub) begin
                    n = 1'b1;
                end
                if (is_cmp) begin
                    co = 1'b1;
                end
            end
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

    assign t_state = state_q[5:0];
    assign hlt     = (state_q == S_HALT);
    assign flag_gt = flag_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. A step-count model predicts the full control
// word on every cycle. Directed scenarios add literal expectations, and
// randomized opcode/cp/clr traffic fills in the rest.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       cp = 1'b0;
    logic ep, inc_pc, lj, lm, ce, li, ei, la, lb, ea, ev, co, n, lo, hlt, flag_gt;
    logic [5:0] t_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model state: the step number 1..6, the halted flag and the compare flag.
    int m_step = 1;
    bit m_halt = 1'b0;
    bit m_flag = 1'b0;

    // Control-word bit masks, in order {ep,inc_pc,lj,lm,ce,li,ei,la,lb,ea,ev,co,n,lo}.
    localparam logic [13:0] M_EP = 14'h2000, M_INC = 14'h1000, M_LJ = 14'h0800,
                            M_LM = 14'h0400, M_CE  = 14'h0200, M_LI = 14'h0100,
                            M_EI = 14'h0080, M_LA  = 14'h0040, M_LB = 14'h0020,
                            M_EA = 14'h0010, M_EV  = 14'h0008, M_CO = 14'h0004,
                            M_N  = 14'h0002, M_LO  = 14'h0001;

    control_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode), .cp(cp),
        .ep(ep), .inc_pc(inc_pc), .lj(lj), .lm(lm), .ce(ce), .li(li), .ei(ei),
        .la(la), .lb(lb), .ea(ea), .ev(ev), .co(co), .n(n), .lo(lo),
        .hlt(hlt), .flag_gt(flag_gt), .t_state(t_state)
    );

    always #5 clk = ~clk;

    // Instruction table: the control word for a step, given the opcode and flag.
    function automatic logic [13:0] exp_ctrl(int step, bit halted, logic [3:0] op, bit flag);
        if (halted) return 14'h0;
        if (step == 1) return M_EP | M_LM;
        if (step == 2) return M_INC;
        if (step == 3) return M_CE | M_LI;
        case (op)
            4'h0: return (step == 4) ? (M_EI | M_LM) : (step == 5) ? (M_CE | M_LA) : 14'h0;
            4'h1: return (step == 4) ? (M_EI | M_LM) : (step == 5) ? (M_CE | M_LB) : (M_EV | M_LA);
            4'h2: return (step == 4) ? (M_EI | M_LM) : (step == 5) ? (M_CE | M_LB | M_N)
                                                                   : (M_EV | M_LA | M_N);
            4'h3: return (step == 4) ? (M_EI | M_LM) : (step == 5) ? (M_CE | M_LB) : M_CO;
            4'h4: return (step == 4 && flag) ? (M_EI | M_LJ) : 14'h0;
            4'h5: return (step == 4) ? (M_EI | M_LJ) : 14'h0;
            4'hE: return (step == 4) ? (M_EA | M_LO) : 14'h0;
            default: return 14'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge, using the same inputs the DUT samples.
    always @(posedge clk) begin
        if (clr) begin
            m_step = 1;
            m_halt = 1'b0;
            m_flag = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 4 && opcode == 4'hF) begin
                m_halt = 1'b1;
            end else if (m_step == 6) begin
                if (opcode == 4'h3) m_flag = cp;
                m_step = 1;
            end else begin
                m_step = m_step + 1;
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            logic [13:0] act_w;
            logic [5:0]  exp_t;
            act_w = {ep, inc_pc, lj, lm, ce, li, ei, la, lb, ea, ev, co, n, lo};
            exp_t = m_halt ? 6'd0 : 6'(1 << (m_step - 1));
            check("ctrl_word", 32'(act_w), 32'(exp_ctrl(m_step, m_halt, opcode, m_flag)));
            check("t_state", 32'(t_state), 32'(exp_t));
            check("hlt", 32'(hlt), 32'(m_halt));
            check("flag_gt", 32'(flag_gt), 32'(m_flag));
            check("bus_excl", 32'($countones({ep, ce, ei, ea, ev}) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_instr(input logic [3:0] op, input bit rand_cp, input bit cp_val);
        opcode = op;
        for (int k = 0; k < 6; k++) begin
            cp = rand_cp ? 1'($urandom) : cp_val;
            tick();
        end
    endtask

    initial begin
        // Hold reset for two edges, then release and check the T1 state.
        clr = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        clr = 1'b0;
        check("rst_t_state", 32'(t_state), 32'h01);
        check("rst_ep_lm", 32'({ep, lm}), 32'h3);
        check("rst_hlt_flag", 32'({hlt, flag_gt}), 32'h0);
        run_instr(4'h0, 1'b0, 1'b0);
        check("ring_wrap", 32'(t_state), 32'h01);

        // ADD and SUB: check T6 literally and let the model cover the other steps.
        opcode = 4'h1;
        repeat (5) tick();
        check("add_t6", 32'({ev, la, n}), 32'h6);
        tick();
        opcode = 4'h2;
        repeat (5) tick();
        check("sub_t6", 32'({ev, la, n}), 32'h7);
        tick();

        // CMP with cp=1, then JGT takes the jump. CMP with cp=0, then JGT does nothing.
        run_instr(4'h3, 1'b0, 1'b1);
        check("cmp1_flag", 32'(flag_gt), 32'h1);
        opcode = 4'h4;
        repeat (3) tick();
        check("jgt_taken", 32'({ei, lj}), 32'h3);
        repeat (3) tick();
        run_instr(4'h3, 1'b0, 1'b0);
        check("cmp0_flag", 32'(flag_gt), 32'h0);
        opcode = 4'h4;
        repeat (3) tick();
        check("jgt_not_taken", 32'({ei, lj}), 32'h0);
        repeat (3) tick();

        // Set the flag, then assert clr in T5 of ADD.
        run_instr(4'h3, 1'b0, 1'b1);
        opcode = 4'h1;
        repeat (4) tick();
        check("add_t5", 32'({ce, lb, la}), 32'h6);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("mid_clr_t1", 32'(t_state), 32'h01);
        check("mid_clr_flag", 32'(flag_gt), 32'h0);

        // Opcode sweep 0x0..0xE with random cp.
        for (int op = 0; op < 15; op++) begin
            run_instr(4'(op), 1'b1, 1'b0);
        end

        // Random opcodes, random cp and occasional clr.
        for (int i = 0; i < 60; i++) begin
            opcode = 4'($urandom_range(0, 14));
            for (int k = 0; k < 6; k++) begin
                cp  = 1'($urandom);
                clr = ($urandom_range(0, 39) == 0);
                tick();
            end
            clr = 1'b0;
        end

        // Realign to T1, set the flag, then HLT. The flag must hold while halted.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run_instr(4'h3, 1'b0, 1'b1);
        opcode = 4'hF;
        repeat (3) tick();
        check("hlt_t4", 32'(t_state), 32'h08);
        tick();
        check("halted_t_state", 32'(t_state), 32'h00);
        check("halted_hlt", 32'(hlt), 32'h1);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom);
            cp     = 1'($urandom);
            tick();
        end
        check("halted_flag_hold", 32'(flag_gt), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("unhalt_t1", 32'(t_state), 32'h01);
        check("unhalt_hlt_flag", 32'({hlt, flag_gt}), 32'h0);
        run_instr(4'h0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control unit for the 8-bit accumulator CPU. It issues the per-cycle control word that drives the register group, program counter, MAR, RAM, instruction register and output register.
- It consumes the register group's compare result (cp) and closes the control loop: the register group receives la/lb/ea/ev/co/n, and this block generates them.
- Implementation: a six-state one-hot T-state ring counter plus a HALT state, with a fixed fetch (T1-T3) and opcode-decoded execute (T4-T6).

Parameters:
- OP_LDA, 4'h0, load A from memory
- OP_ADD, 4'h1, A <= A + mem
- OP_SUB, 4'h2, A <= A + mem through n-path
- OP_CMP, 4'h3, load B from mem, latch compare flag
- OP_JGT, 4'h4, jump if compare flag set
- OP_JMP, 4'h5, unconditional jump
- OP_OUT, 4'hE, A -> output register
- OP_HLT, 4'hF, halt

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  reset, synchronous, active-high
- opcode  input  4  IR upper nibble, valid T4-T6
- cp  input  1  compare result from register group (A>B gated by co)
- ep  output  1  PC drives bus
- inc_pc  output  1  PC increment
- lj  output  1  PC load from bus
- lm  output  1  MAR load
- ce  output  1  RAM drives bus
- li  output  1  IR load
- ei  output  1  IR operand drives bus
- la  output  1  A load
- lb  output  1  B load
- ea  output  1  A drives bus
- ev  output  1  adder drives bus
- co  output  1  compare gate to register group
- n  output  1  B-path alternate (subtract) mode
- lo  output  1  output register load
- hlt  output  1  halted status
- flag_gt  output  1  latched compare flag
- t_state  output  6  one-hot T1..T6 (bit0=T1), 0 when halted

Behaviour:
- Reset: at any rising edge with clr=1 the next state is T1 (t_state=6'b000001). clr clears flag_gt=0 and hlt=0. All control outputs are combinational decode of state, so they are 0 except the T1 ones (ep=1, lm=1). clr wins over every other event, including mid-instruction and HALT.
- Sequencing:
  - T1->T2->...->T6->T1, one state per clk, every instruction is 6 cycles.
  - No early exit except HLT.
- Fetch, identical for all opcodes:
  - T1: ep, lm
  - T2: inc_pc
  - T3: ce, li
- Execute (signals not listed are 0):
  - LDA: T4 ei,lm; T5 ce,la; T6 none.
  - ADD: T4 ei,lm; T5 ce,lb; T6 ev,la.
  - SUB: T4 ei,lm; T5 ce,lb,n; T6 ev,la,n.
  - CMP: T4 ei,lm; T5 ce,lb; T6 co. flag_gt <= cp at the T6->T1 edge.
  - JGT: T4 ei,lj only if flag_gt=1, else none; T5/T6 none.
  - JMP: T4 ei,lj; T5/T6 none.
  - OUT: T4 ea,lo; T5/T6 none.
  - HLT: at the T4 edge go to HALT. In HALT: hlt=1, t_state=0, all control outputs 0, opcode and cp ignored. Leave HALT only via clr.
  - Undefined opcodes: NOP (T4-T6 all 0), then continue to T1.
- flag_gt: written only at the end of CMP T6; holds otherwise, including across JGT and while halted.
- Bus exclusivity invariant: at most one of {ep, ce, ei, ea, ev} is high in any cycle.
- Output timing: outputs change only after a clk edge; there is no combinational path from cp to any output, and opcode affects outputs only in T4-T6.

Test Plan:
- Reset: hold clr 2 cycles, release -> t_state=000001, ep=lm=1, hlt=0, flag_gt=0. 6 cycles later t_state=000001 again.
- ADD (opcode=1): cycle-by-cycle -> T4 ei/lm, T5 ce/lb, T6 ev/la, n=0 throughout. Repeat with SUB (opcode=2) -> same pattern with n=1 in T5,T6.
- CMP then JGT: CMP with cp=1 at T6 -> flag_gt=1. Next JGT -> T4 ei=lj=1. Repeat with cp=0 -> flag_gt=0, JGT T4 all 0.
- HLT (opcode=F): -> after T4 edge hlt=1, t_state=0, all controls 0 for 20 cycles despite opcode toggling. Then clr=1 for one edge -> T1, hlt=0.
- clr asserted during T5 of ADD -> next cycle T1, la never asserted, flag_gt cleared.
- Opcode sweep 0x0-0xF, random cp -> bus-exclusivity invariant never violated; opcodes 6-D produce NOP execute.
